// File: rtl/cla_addsub_pipe_pkg.sv
// cla_pkg: shared types and helpers for the pipelined carry-lookahead
// adder/subtractor (cla_addsub_pipe).
//   op_e          - operation encoding carried on in_op
//   eff_carry_in  - carry injected into bit 0 for each operation
//   cfg_ok        - parameter legality check used at elaboration
package cla_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,   // a + b
        OP_SUB = 2'b01,   // a - b
        OP_ADC = 2'b10,   // a + b + ci
        OP_SBB = 2'b11    // a - b - ci
    } op_e;

    // Subtraction is a + ~b + 1, so a borrow-in removes that +1.
    function automatic logic eff_carry_in(input op_e op, input logic ci);
        case (op)
            OP_ADD:  return 1'b0;
            OP_SUB:  return 1'b1;
            OP_ADC:  return ci;
            default: return ~ci;
        endcase
    endfunction

    // WIDTH must split into STAGES equal chunks, each a whole number of groups.
    function automatic bit cfg_ok(input int width, input int stages, input int group);
        return (stages >= 1) && (stages <= 8) && (group >= 1) &&
               ((width % stages) == 0) && (((width / stages) % group) == 0);
    endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// cla_addsub_pipe_if: operand/result handshake bundle for cla_addsub_pipe.
//   in_valid/in_ready   operand beat handshake (in_op, in_a, in_b, in_ci[, in_sat])
//   out_valid/out_ready result handshake (out_s, out_co, out_ovf, out_zero, out_neg)
// Handshake: a beat transfers on a rising clock edge where valid and ready are
// both high; the producer keeps valid and payload stable until that edge, and
// ready may depend combinationally on the consumer side but never on valid.
// Optional: CLA_ADDSUB_SAT_EN adds in_sat (saturate on signed overflow).
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
`ifdef CLA_ADDSUB_SAT_EN
    logic             in_sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_co;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;

    // Upstream/downstream side (drives operands, accepts results).
    modport master (
        output in_valid, in_op, in_a, in_b, in_ci,
`ifdef CLA_ADDSUB_SAT_EN
        output in_sat,
`endif
        output out_ready,
        input  in_ready, out_valid, out_s, out_co, out_ovf, out_zero, out_neg
    );

    // Adder side.
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_ci,
`ifdef CLA_ADDSUB_SAT_EN
        input  in_sat,
`endif
        input  out_ready,
        output in_ready, out_valid, out_s, out_co, out_ovf, out_zero, out_neg
    );

endinterface

// File: rtl/cla_addsub_pipe_chunk.sv
// cla_chunk: combinational CW-bit carry-lookahead adder.
//   a, b : CW-bit operands (b already inverted for subtraction)
//   ci   : carry into bit 0
//   s    : CW-bit sum
//   co   : carry out of bit CW-1
// Bits are grouped GROUP at a time into generate/propagate pairs; a single
// second-level lookahead forms every group carry directly from the group
// G/P terms and ci, so no carry ripples from group to group.
module cla_chunk #(
    parameter int CW    = 16,
    parameter int GROUP = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    localparam int NG = CW / GROUP;

    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;

    assign g = a & b;
    assign p = a ^ b;

    // {group generate, group propagate}
    function automatic logic [1:0] group_gp(input logic [GROUP-1:0] gv,
                                            input logic [GROUP-1:0] pv);
        logic gacc;
        logic pacc;
        gacc = 1'b0;
        pacc = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
            gacc = gv[i] | (pv[i] & gacc);
            pacc = pacc & pv[i];
        end
        return {gacc, pacc};
    endfunction

    // Each carry is expanded independently from G/P and the chunk carry-in.
    function automatic logic [NG:0] group_carries(input logic [NG-1:0] gv,
                                                  input logic [NG-1:0] pv,
                                                  input logic          cin);
        logic [NG:0] c;
        logic        acc;
        c[0] = cin;
        for (int j = 1; j <= NG; j++) begin
            acc = cin;
            for (int i = 0; i < j; i++) begin
                acc = gv[i] | (pv[i] & acc);
            end
            c[j] = acc;
        end
        return c;
    endfunction

    function automatic logic [GROUP-1:0] group_sum(input logic [GROUP-1:0] gv,
                                                   input logic [GROUP-1:0] pv,
                                                   input logic             cin);
        logic [GROUP-1:0] sv;
        logic             c;
        c = cin;
        for (int i = 0; i < GROUP; i++) begin
            sv[i] = pv[i] ^ c;
            c     = gv[i] | (pv[i] & c);
        end
        return sv;
    endfunction

    for (genvar j = 0; j < NG; j++) begin : g_grp
        assign {grp_g[j], grp_p[j]} = group_gp(g[j*GROUP +: GROUP], p[j*GROUP +: GROUP]);
        assign s[j*GROUP +: GROUP]  = group_sum(g[j*GROUP +: GROUP], p[j*GROUP +: GROUP], grp_c[j]);
    end

    assign grp_c = group_carries(grp_g, grp_p, ci);
    assign co    = grp_c[NG];

endmodule

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead adder/subtractor.
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset
//   bus  : cla_addsub_pipe_if.slave (operand and result handshakes)
// Parameters: WIDTH (operand width), STAGES (1..8 pipeline stages, one
// WIDTH/STAGES chunk resolved per stage), GROUP (lookahead group size).
// Optional: define CLA_ADDSUB_SAT_EN to enable in_sat saturation.
//
// The pipe moves as a whole: every stage loads from its predecessor when the
// output register is empty or being drained, otherwise everything holds.
// Stage k keeps only the operand chunks it has not yet consumed and the sum
// chunks already finished, plus the carry into the next chunk.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input logic              clk,
    input logic              clrn,
    cla_addsub_pipe_if.slave bus
);

    localparam int CW     = WIDTH / STAGES;
    localparam bit CFG_OK = cfg_ok(WIDTH, STAGES, GROUP);

    if (!CFG_OK) begin : g_cfg_err
        $error("cla_addsub_pipe: WIDTH/STAGES/GROUP combination is not legal");
    end

    logic             advance;
    op_e              op_in;
    logic             sub_in;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_s_q;
    logic             out_co_q;
    logic             out_ovf_q;
    logic             out_zero_q;
    logic             out_neg_q;

    assign op_in  = op_e'(bus.in_op);
    assign sub_in = bus.in_op[0];
    assign b_eff  = sub_in ? ~bus.in_b : bus.in_b;
    assign c0     = eff_carry_in(op_in, bus.in_ci);

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = out_s_q;
    assign bus.out_co    = out_co_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_neg   = out_neg_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;        // first bit resolved by this stage
        localparam int PW = WIDTH - LO;    // operand bits still pending here

        logic [PW-1:0]    a_src;
        logic [PW-1:0]    b_src;
        logic             c_src;
        logic             v_src;
        logic             sub_src;
`ifdef CLA_ADDSUB_SAT_EN
        logic             sat_src;
`endif
        logic [CW-1:0]    s_ch;
        logic             co_ch;
        logic [LO+CW-1:0] s_new;

        if (k == 0) begin : g_src
            assign a_src   = bus.in_a;
            assign b_src   = b_eff;
            assign c_src   = c0;
            assign v_src   = bus.in_valid;
            assign sub_src = sub_in;
`ifdef CLA_ADDSUB_SAT_EN
            assign sat_src = bus.in_sat;
`endif
            assign s_new   = s_ch;
        end else begin : g_src
            assign a_src   = g_stage[k-1].g_mid.a_q;
            assign b_src   = g_stage[k-1].g_mid.b_q;
            assign c_src   = g_stage[k-1].g_mid.c_q;
            assign v_src   = g_stage[k-1].g_mid.v_q;
            assign sub_src = g_stage[k-1].g_mid.sub_q;
`ifdef CLA_ADDSUB_SAT_EN
            assign sat_src = g_stage[k-1].g_mid.sat_q;
`endif
            assign s_new   = {s_ch, g_stage[k-1].g_mid.s_q};
        end

        cla_chunk #(
            .CW    (CW),
            .GROUP (GROUP)
        ) u_chunk (
            .a  (a_src[CW-1:0]),
            .b  (b_src[CW-1:0]),
            .ci (c_src),
            .s  (s_ch),
            .co (co_ch)
        );

        if (k < STAGES - 1) begin : g_mid
            logic [PW-CW-1:0] a_q;
            logic [PW-CW-1:0] b_q;
            logic [LO+CW-1:0] s_q;
            logic             c_q;
            logic             v_q;
            logic             sub_q;
`ifdef CLA_ADDSUB_SAT_EN
            logic             sat_q;
`endif

            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                    c_q   <= 1'b0;
                    v_q   <= 1'b0;
                    sub_q <= 1'b0;
`ifdef CLA_ADDSUB_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (advance) begin
                    a_q   <= a_src[PW-1:CW];
                    b_q   <= b_src[PW-1:CW];
                    s_q   <= s_new;
                    c_q   <= co_ch;
                    v_q   <= v_src;
                    sub_q <= sub_src;
`ifdef CLA_ADDSUB_SAT_EN
                    sat_q <= sat_src;
`endif
                end
            end
        end else begin : g_last
            logic             a_msb;
            logic             b_msb;
            logic             ovf;
            logic [WIDTH-1:0] res;

            // b_src is already inverted for subtraction, so the add-form
            // overflow rule covers both directions.
            assign a_msb = a_src[PW-1];
            assign b_msb = b_src[PW-1];
            assign ovf   = (a_msb == b_msb) && (s_new[WIDTH-1] != a_msb);

`ifdef CLA_ADDSUB_SAT_EN
            assign res = (sat_src && ovf) ?
                         (a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
                         s_new;
`else
            assign res = s_new;
`endif

            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    out_valid_q <= 1'b0;
                    out_s_q     <= '0;
                    out_co_q    <= 1'b0;
                    out_ovf_q   <= 1'b0;
                    out_zero_q  <= 1'b0;
                    out_neg_q   <= 1'b0;
                end else if (advance) begin
                    out_valid_q <= v_src;
                    out_s_q     <= res;
                    // Raw carry is inverted for subtraction to report a borrow.
                    out_co_q    <= co_ch ^ sub_src;
                    out_ovf_q   <= ovf;
                    out_zero_q  <= (res == '0);
                    out_neg_q   <= res[WIDTH-1];
                end
            end
        end
    end

endmodule
